mem_access_unit: RTL and testbench
==================================

# mem_access_unit

MEM-stage data-memory access controller for the 5-stage MIPS pipeline. Sits between the EX/MEM pipeline register and the MEM/WB register. It decodes the load/store opcode of `instrM` and drives a request/acknowledge data-memory bus with byte enables. It performs load sign/zero extension and produces `ReadDataM` for MEM/WB, stalling the whole pipeline until each access completes, errors out or times out.

## Interface
Parameters:
- `TIMEOUT`, 16: max cycles `dm_req` stays high without `dm_ack` before abort (≥2).

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `instrM`  in  32  instruction in MEM; held constant by upstream while `stallM`=1.
- `ALUOutM`  in  32  effective byte address.
- `WriteDataM`  in  32  store data (rt value).
- `ReadDataM`  out  32  extended load data to MEM/WB.
- `stallM`  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; hold MEM/WB.
- `addr_err`  out  1  one-cycle pulse, misaligned access.
- `bus_err`  out  1  one-cycle pulse, access timed out.
- `dm_req`  out  1  bus request.
- `dm_we`  out  1  1 = write.
- `dm_addr`  out  32  word address, `{ALUOutM[31:2],2'b00}`.
- `dm_be`  out  4  byte enables; bit i = bits 8i+7:8i.
- `dm_wdata`  out  32  lane-replicated store data.
- `dm_rdata`  in  32  read data, valid when `dm_ack`=1.
- `dm_ack`  in  1  access complete.

## Operation
- Little-endian lanes: byte offset k = `ALUOutM[1:0]` ↔ bits 8k+7:8k.
- Opcodes (`instrM[31:26]`): lb 0x20, lh 0x21, lw 0x23, lbu 0x24, lhu 0x25, sb 0x28, sh 0x29, sw 0x2B. All others are non-memory.
- Store data replication:
  - sb: `{4{WriteDataM[7:0]}}`, be = 1<<k.
  - sh: `{2{WriteDataM[15:0]}}`, be = 0011 (k=0) or 1100 (k=2).
  - sw: `WriteDataM`, be = 1111.
- Load byte enables use the same be rules as stores; `dm_wdata` is don't-care on loads.
- Load extension on capture:
  - lb/lh sign-extend the selected lane.
  - lbu/lhu zero-extend the selected lane.
  - lw passes the word through.
- Misalignment: lh/lhu/sh with `ALUOutM[0]`=1, or lw/sw with `ALUOutM[1:0]`≠0.
- FSM states IDLE, REQ, DONE:
  - IDLE, non-memory op: `stallM`=0, no request, stay.
  - IDLE, misaligned op: `addr_err`=1 this cycle, `stallM`=0, no request; `ReadDataM` unchanged. Stores are suppressed.
  - IDLE, aligned op: `stallM`=1, go to REQ, clear timeout counter.
  - REQ: `dm_req`=1, `stallM`=1; bus outputs stable. Counter increments each cycle without ack.
  - REQ, `dm_ack`=1: capture extended data (loads only), go to DONE.
  - REQ, counter = TIMEOUT−1 with no ack: `bus_err`=1 this cycle, go to DONE. Captured data is forced to 0 for loads.
  - DONE: `stallM`=0, `dm_req`=0, go to IDLE. The pipeline advances on this edge.
- `ReadDataM` is a register that changes only on load capture.

## Timing
- Reset values: FSM=IDLE, `ReadDataM`=0, counter=0, `dm_req`=0, `stallM`=0, `addr_err`=0, `bus_err`=0, `dm_be`=0, `dm_we`=0.
- Reset mid-access: the FSM drops to IDLE and `dm_req` deasserts asynchronously. No capture occurs; a late `dm_ack` is ignored.
- Memory op latency: 1 (IDLE) + N (REQ, N≥1 = cycles to ack) + 1 (DONE) = N+2 cycles in MEM.
- Non-memory and misaligned ops take 1 cycle.
- `dm_ack` is sampled only in REQ; ack in IDLE or DONE is ignored.
- `stallM` is combinational from state and `instrM`: 1 in REQ, and 1 in IDLE with an aligned memory op.
- Ack and timeout in the same cycle: ack wins, `bus_err`=0.
- Back-to-back memory ops: DONE→IDLE, then the new op starts its IDLE stall cycle immediately.

## Test plan
- **lw, zero-wait-state memory:** addr 0x1000, `dm_rdata`=0xDEADBEEF, ack in the first REQ cycle → `dm_req` high exactly 1 cycle, `stallM` high 2 cycles, `ReadDataM`=0xDEADBEEF in DONE.
- **lb/lbu on lane 3:** addr 0x1003, rdata 0x80FF_FF7F → lb gives 0xFFFFFF80, lbu gives 0x00000080, `dm_be`=1000.
- **sh at offset 2:** WriteDataM 0x1234ABCD → `dm_we`=1, `dm_be`=1100, `dm_wdata`=0xABCDABCD, `ReadDataM` unchanged.
- **Misaligned lw:** addr 0x1002 → `addr_err` pulses 1 cycle, `dm_req` never asserts, `stallM`=0.
- **Timeout:** TIMEOUT=16, never ack → `dm_req` high 16 cycles, then `bus_err` pulse, DONE, `ReadDataM`=0.
- **Reset mid-access:** assert `rst` on the 3rd REQ cycle → `dm_req`/`stallM` drop immediately, `ReadDataM`=0. An ack the following cycle is ignored.

Source files
------------

// File: rtl/mem_access_unit.sv
`default_nettype none
// ==== mem_access_unit : MEM-stage load/store controller on a req/ack data bus ====
// ==== Rev 1.0                                                                 ====
module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instrM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        stallM,
  output logic        addr_err,
  output logic        bus_err,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  logic [5:0]  opcode;
  logic [1:0]  k;
  logic [2:0]  size;
  logic        is_load;
  logic        is_store;
  logic        is_signed;
  logic        mem_op;
  logic        misaligned;
  logic        timeout_hit;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_ext;
  logic        unused_instr;

  assign opcode       = instrM[31:26];
  assign k            = ALUOutM[1:0];
  assign unused_instr = ^instrM[25:0];

  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_signed = 1'b0;
    size      = 3'd0;
    case (opcode)
      6'h20: begin is_load  = 1'b1; is_signed = 1'b1; size = 3'd1; end
      6'h21: begin is_load  = 1'b1; is_signed = 1'b1; size = 3'd2; end
      6'h23: begin is_load  = 1'b1; size = 3'd4; end
      6'h24: begin is_load  = 1'b1; size = 3'd1; end
      6'h25: begin is_load  = 1'b1; size = 3'd2; end
      6'h28: begin is_store = 1'b1; size = 3'd1; end
      6'h29: begin is_store = 1'b1; size = 3'd2; end
      6'h2B: begin is_store = 1'b1; size = 3'd4; end
      default: ;
    endcase
  end

  assign mem_op     = is_load | is_store;
  assign misaligned = ((size == 3'd2) && k[0]) || ((size == 3'd4) && (k != 2'b00));

  // Byte enables and lane-replicated store data; loads reuse the same enables.
  always_comb begin
    be    = 4'b0000;
    wdata = WriteDataM;
    case (size)
      3'd1: begin be = 4'b0001 << k; wdata = {4{WriteDataM[7:0]}}; end
      3'd2: begin be = k[1] ? 4'b1100 : 4'b0011; wdata = {2{WriteDataM[15:0]}}; end
      3'd4: be = 4'b1111;
      default: ;
    endcase
  end

  always_comb begin
    case (k)
      2'd0:    lane_b = dm_rdata[7:0];
      2'd1:    lane_b = dm_rdata[15:8];
      2'd2:    lane_b = dm_rdata[23:16];
      default: lane_b = dm_rdata[31:24];
    endcase
    lane_h = k[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    case (size)
      3'd1:    load_ext = {{24{is_signed & lane_b[7]}}, lane_b};
      3'd2:    load_ext = {{16{is_signed & lane_h[15]}}, lane_h};
      default: load_ext = dm_rdata;
    endcase
  end

  // Ack has priority over timeout in the same cycle.
  assign timeout_hit = (state == REQ) && !dm_ack && (cnt == CW'(TIMEOUT - 1));
  assign dm_req      = (state == REQ);
  assign stallM      = !rst && (dm_req || ((state == IDLE) && mem_op && !misaligned));
  assign addr_err    = !rst && (state == IDLE) && mem_op && misaligned;
  assign bus_err     = !rst && timeout_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      ReadDataM <= '0;
      dm_we     <= 1'b0;
      dm_be     <= '0;
      dm_addr   <= '0;
      dm_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_op && !misaligned) begin
            state    <= REQ;
            cnt      <= '0;
            dm_we    <= is_store;
            dm_be    <= be;
            dm_addr  <= {ALUOutM[31:2], 2'b00};
            dm_wdata <= wdata;
          end
        end
        REQ: begin
          if (dm_ack) begin
            if (is_load) ReadDataM <= load_ext;
            state <= DONE;
            dm_we <= 1'b0;
            dm_be <= '0;
          end else if (timeout_hit) begin
            if (is_load) ReadDataM <= '0;
            state <= DONE;
            dm_we <= 1'b0;
            dm_be <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ==== tb_mem_access_unit : randomized bench for mem_access_unit with reference model ====
`timescale 1ns/1ps
module tb_mem_access_unit;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instrM, ALUOutM, WriteDataM, ReadDataM;
  logic        stallM, addr_err, bus_err, dm_req, dm_we, dm_ack;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_be;

  int          total = 0;
  int          passed = 0;
  int          fails = 0;
  logic [31:0] exp_rd;

  mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .instrM(instrM), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
    .ReadDataM(ReadDataM), .stallM(stallM), .addr_err(addr_err), .bus_err(bus_err),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Opcode table: access size in bytes (0 = not a memory op), direction, signedness.
  function automatic void decode(input logic [5:0] op, output int size, output bit ld,
                                 output bit st, output bit sgn);
    size = 0; ld = 0; st = 0; sgn = 0;
    case (op)
      6'h20: begin size = 1; ld = 1; sgn = 1; end
      6'h21: begin size = 2; ld = 1; sgn = 1; end
      6'h23: begin size = 4; ld = 1; end
      6'h24: begin size = 1; ld = 1; end
      6'h25: begin size = 2; ld = 1; end
      6'h28: begin size = 1; st = 1; end
      6'h29: begin size = 2; st = 1; end
      6'h2B: begin size = 4; st = 1; end
      default: ;
    endcase
  endfunction

  // One instruction through MEM; ack_at = REQ cycle index carrying ack, -1 = never.
  task automatic run_op(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        input int ack_at, input logic [31:0] rdat);
    int size, k;
    bit ld, st, sgn, done;
    logic [31:0] mask, be_exp, wd_exp, v;
    decode(op, size, ld, st, sgn);
    k = int'(addr % 4);
    @(negedge clk);
    instrM = {op, 26'($urandom)};
    ALUOutM = addr;
    WriteDataM = wd;
    dm_ack = 1'($urandom_range(0, 1));
    dm_rdata = $urandom;
    #1;
    if (size == 0) begin
      check("nonmem_stall", stallM, 0);
      check("nonmem_req", dm_req, 0);
      check("nonmem_aerr", addr_err, 0);
      return;
    end
    if ((addr % size) != 0) begin
      check("mis_aerr", addr_err, 1);
      check("mis_stall", stallM, 0);
      check("mis_req", dm_req, 0);
      @(negedge clk);
      instrM = 32'h0;
      dm_ack = 1'b0;
      #1;
      check("mis_req_after", dm_req, 0);
      check("mis_aerr_after", addr_err, 0);
      check("mis_rd", ReadDataM, exp_rd);
      return;
    end
    check("idle_stall", stallM, 1);
    check("idle_req", dm_req, 0);
    check("idle_aerr", addr_err, 0);
    mask   = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 1);
    be_exp = ((1 << size) - 1) << k;
    wd_exp = (size == 1) ? wd[7:0] * 32'h0101_0101 :
             (size == 2) ? wd[15:0] * 32'h0001_0001 : wd;
    done = 0;
    for (int i = 0; i < TIMEOUT + 2 && !done; i++) begin
      @(negedge clk);
      dm_ack = (i == ack_at);
      dm_rdata = dm_ack ? rdat : $urandom;
      #1;
      check("req", dm_req, 1);
      check("req_stall", stallM, 1);
      check("be", dm_be, be_exp);
      check("we", dm_we, st);
      check("addr", dm_addr, {addr[31:2], 2'b00});
      if (st) check("wdata", dm_wdata, wd_exp);
      check("bus_err", bus_err, (i == TIMEOUT - 1) && (ack_at != i));
      if (dm_ack) begin
        if (ld) begin
          v = (dm_rdata >> (8 * k)) & mask;
          if (sgn && v[8 * size - 1]) v = v | ~mask;
          exp_rd = v;
        end
        done = 1;
      end else if (i == TIMEOUT - 1) begin
        if (ld) exp_rd = 32'h0;
        done = 1;
      end
      if (!dm_req) done = 1;
    end
    @(negedge clk);
    dm_ack = 1'($urandom_range(0, 1));
    dm_rdata = $urandom;
    #1;
    check("done_req", dm_req, 0);
    check("done_stall", stallM, 0);
    check("done_berr", bus_err, 0);
    check("done_rd", ReadDataM, exp_rd);
  endtask

  initial begin
    logic [5:0] ops [10];
    int ack_at;
    ops = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h00, 6'h0F};
    rst = 1'b0; instrM = 32'h0; ALUOutM = 32'h0; WriteDataM = 32'h0;
    dm_ack = 1'b0; dm_rdata = 32'h0; exp_rd = 32'h0;
    #2 rst = 1'b1;
    #1;
    check("rst_rd", ReadDataM, 0);
    check("rst_req", dm_req, 0);
    check("rst_stall", stallM, 0);
    check("rst_aerr", addr_err, 0);
    check("rst_berr", bus_err, 0);
    check("rst_be", dm_be, 0);
    check("rst_we", dm_we, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op(6'h23, 32'h0000_1000, 32'h0, 0, 32'hDEAD_BEEF);
    check("lw_const", ReadDataM, 32'hDEAD_BEEF);
    run_op(6'h20, 32'h0000_1003, 32'h0, 1, 32'h80FF_FF7F);
    check("lb_const", ReadDataM, 32'hFFFF_FF80);
    run_op(6'h24, 32'h0000_1003, 32'h0, 2, 32'h80FF_FF7F);
    check("lbu_const", ReadDataM, 32'h0000_0080);
    run_op(6'h29, 32'h0000_1002, 32'h1234_ABCD, 0, 32'h0);
    check("sh_keep_rd", ReadDataM, 32'h0000_0080);
    run_op(6'h23, 32'h0000_1002, 32'h0, 0, 32'h0);
    run_op(6'h21, 32'h0000_2002, 32'h0, TIMEOUT - 1, 32'h9234_0000);
    check("ack_at_limit", ReadDataM, 32'hFFFF_9234);
    run_op(6'h23, 32'h0000_2000, 32'h0, -1, 32'h0);
    check("timeout_rd", ReadDataM, 32'h0);

    for (int n = 0; n < 80; n++) begin
      ack_at = ($urandom_range(0, 19) == 0) ? -1 : int'($urandom_range(0, 3));
      run_op(ops[$urandom_range(0, 9)], $urandom, $urandom, ack_at, $urandom);
    end

    run_op(6'h23, 32'h0000_4000, 32'h0, 0, 32'h5A5A_1234);
    @(negedge clk);
    instrM = {6'h23, 26'h0}; ALUOutM = 32'h0000_3000; dm_ack = 1'b0;
    #1 check("rst_mid_idle_stall", stallM, 1);
    repeat (2) begin
      @(negedge clk);
      #1 check("rst_mid_req", dm_req, 1);
    end
    @(negedge clk);
    #1 check("rst_mid_req3", dm_req, 1);
    rst = 1'b1;
    exp_rd = 32'h0;
    #1;
    check("rst_mid_req_drop", dm_req, 0);
    check("rst_mid_stall_drop", stallM, 0);
    check("rst_mid_rd", ReadDataM, 0);
    @(negedge clk);
    rst = 1'b0; instrM = 32'h0; dm_ack = 1'b1; dm_rdata = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    check("late_ack_req", dm_req, 0);
    check("late_ack_stall", stallM, 0);
    check("late_ack_rd", ReadDataM, 0);
    dm_ack = 1'b0;
    run_op(6'h25, 32'h0000_5002, 32'h0, 1, 32'hF00D_0000);
    check("lhu_const", ReadDataM, 32'h0000_F00D);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
